lcd_fifo_reader: RTL and testbench

Consumer end of the LCD init/text FIFO. Pops bytes written by the FIFO loader, classifies each byte as an HD44780 command (RS=0) or character data (RS=1), and drives the 8-bit parallel LCD bus with enable-pulse and execution timing. Sits between the FIFO read port and the LCD pins. Write-only to the LCD; busy-flag polling is not used.

---
 rtl/lcd_pkg.sv | 37 +++
 rtl/lcd_delay_counter.sv | 26 ++
 rtl/lcd_fifo_reader.sv | 142 ++++++++++++++
 tb/tb_lcd_fifo_reader.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared definitions for the LCD FIFO reader: FSM state encoding, HD44780
// command bytes and default bus timing for a 50 MHz clock.
package lcd_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_READ  = 3'd1,
    ST_LATCH = 3'd2,
    ST_SETUP = 3'd3,
    ST_EHIGH = 3'd4,
    ST_HOLD  = 3'd5,
    ST_WAIT  = 3'd6
  } lcd_state_e;

  localparam logic [7:0] CLEAR         = 8'h01;
  localparam logic [7:0] HOME          = 8'h02;
  localparam logic [7:0] FUNC_SET_8BIT = 8'h38;
  localparam logic [7:0] DISP_ON       = 8'h0C;
  localparam logic [7:0] ENTRY_INC     = 8'h06;

  localparam int unsigned DEF_CMD_COUNT = 4;
  localparam int unsigned DEF_T_AS      = 50;
  localparam int unsigned DEF_T_PW      = 25;
  localparam int unsigned DEF_T_H       = 10;
  localparam int unsigned DEF_T_EXEC    = 2000;
  localparam int unsigned DEF_T_CLR     = 76000;

  // A zero-length phase still occupies one clock.
  function automatic int unsigned at_least_one(input int unsigned t);
    return (t == 0) ? 1 : t;
  endfunction

  function automatic int unsigned max2(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/lcd_delay_counter.sv
// Loadable down-counter timing every LCD bus phase; done marks the final
// cycle of the loaded interval (a load of 0 or 1 is a one-cycle interval).
module lcd_delay_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] value,
  output logic         done
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (value != '0) begin
      value <= value - W'(1);
    end
  end

  assign done = (value <= W'(1));

endmodule

// File: rtl/lcd_fifo_reader.sv
// Pops bytes from the LCD FIFO and drives the HD44780 8-bit write bus with
// setup / enable / hold / execution timing; leading bytes are commands.
module lcd_fifo_reader
  import lcd_pkg::*;
#(
  parameter int unsigned CMD_COUNT = DEF_CMD_COUNT,
  parameter int unsigned T_AS      = DEF_T_AS,
  parameter int unsigned T_PW      = DEF_T_PW,
  parameter int unsigned T_H       = DEF_T_H,
  parameter int unsigned T_EXEC    = DEF_T_EXEC,
  parameter int unsigned T_CLR     = DEF_T_CLR
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       empty,
  input  logic [7:0] Data_out,
  output logic       rd_en,
  output logic       LCD_RS,
  output logic       LCD_RW,
  output logic       LCD_E,
  output logic [7:0] LCD_DATA,
  output logic       busy,
  output logic [7:0] byte_cnt
);

  localparam int unsigned AS_C   = at_least_one(T_AS);
  localparam int unsigned PW_C   = at_least_one(T_PW);
  localparam int unsigned H_C    = at_least_one(T_H);
  localparam int unsigned EXEC_C = at_least_one(T_EXEC);
  localparam int unsigned CLR_C  = at_least_one(T_CLR);
  localparam int unsigned MAX_T  = max2(max2(max2(AS_C, PW_C), max2(H_C, EXEC_C)), CLR_C);
  localparam int unsigned CW     = $clog2(MAX_T) + 1;

  lcd_state_e    state;
  logic          use_clr;
  logic          is_data;
  logic          is_clr;
  logic          dly_load;
  logic [CW-1:0] dly_val;
  logic [CW-1:0] dly_value;
  logic          dly_done;
  logic          dly_expired;

  lcd_delay_counter #(.W(CW)) u_delay (
    .clk      (clk),
    .rst      (rst),
    .load     (dly_load),
    .load_val (dly_val),
    .value    (dly_value),
    .done     (dly_done)
  );

  assign dly_expired = dly_done || (dly_value == '0);
  assign is_data     = ({24'd0, byte_cnt} >= CMD_COUNT);
  assign is_clr      = !is_data && (Data_out[7:2] == 6'd0) && (Data_out[1:0] != 2'd0);
  assign LCD_RW      = 1'b0;

  // The counter is reloaded on the last cycle of each phase so the next
  // phase sees its full length starting on its first cycle.
  always_comb begin
    dly_load = 1'b0;
    dly_val  = '0;
    case (state)
      ST_LATCH: begin
        dly_load = 1'b1;
        dly_val  = CW'(AS_C);
      end
      ST_SETUP: begin
        dly_load = dly_expired;
        dly_val  = CW'(PW_C);
      end
      ST_EHIGH: begin
        dly_load = dly_expired;
        dly_val  = CW'(H_C);
      end
      ST_HOLD: begin
        dly_load = dly_expired;
        dly_val  = use_clr ? CW'(CLR_C) : CW'(EXEC_C);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= ST_IDLE;
      rd_en    <= 1'b0;
      LCD_RS   <= 1'b0;
      LCD_E    <= 1'b0;
      LCD_DATA <= '0;
      busy     <= 1'b0;
      byte_cnt <= '0;
      use_clr  <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (!empty) begin
            state <= ST_READ;
            rd_en <= 1'b1;
            busy  <= 1'b1;
          end
        end
        ST_READ: begin
          rd_en <= 1'b0;
          state <= ST_LATCH;
        end
        ST_LATCH: begin
          LCD_DATA <= Data_out;
          LCD_RS   <= is_data;
          use_clr  <= is_clr;
          state    <= ST_SETUP;
        end
        ST_SETUP: begin
          if (dly_expired) begin
            LCD_E <= 1'b1;
            state <= ST_EHIGH;
          end
        end
        ST_EHIGH: begin
          if (dly_expired) begin
            LCD_E <= 1'b0;
            state <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (dly_expired) begin
            if (byte_cnt != 8'hFF) byte_cnt <= byte_cnt + 8'd1;
            state <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          if (dly_expired) begin
            busy  <= 1'b0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_fifo_reader.sv
// Bench for lcd_fifo_reader: FIFO model, bus event monitor and per-scenario
// tasks compared against per-byte timing rules.
module tb_lcd_fifo_reader;

  localparam int P_AS   = 2;
  localparam int P_PW   = 4;
  localparam int P_H    = 2;
  localparam int P_EXEC = 10;
  localparam int P_CLR  = 50;
  localparam int P_CMD  = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       empty = 1'b1;
  logic [7:0] Data_out = 8'h00;
  logic       rd_en, LCD_RS, LCD_RW, LCD_E, busy;
  logic [7:0] LCD_DATA, byte_cnt;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  lcd_fifo_reader #(
    .CMD_COUNT (P_CMD),
    .T_AS      (P_AS),
    .T_PW      (P_PW),
    .T_H       (P_H),
    .T_EXEC    (P_EXEC),
    .T_CLR     (P_CLR)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .empty    (empty),
    .Data_out (Data_out),
    .rd_en    (rd_en),
    .LCD_RS   (LCD_RS),
    .LCD_RW   (LCD_RW),
    .LCD_E    (LCD_E),
    .LCD_DATA (LCD_DATA),
    .busy     (busy),
    .byte_cnt (byte_cnt)
  );

  // FIFO model: data appears the cycle after the pop strobe.
  logic [7:0] fifo_q[$];
  bit         glitch_low = 1'b0;

  always @(posedge clk)
    if (rd_en && fifo_q.size() > 0) Data_out <= fifo_q.pop_front();

  always @(negedge clk)
    empty = glitch_low ? 1'b0 : (fifo_q.size() == 0);

  // Bus monitor, sampled on the falling edge.
  int         cyc = 0;
  logic       e_prev = 1'b0;
  int         rd_q[$];
  int         rise_q[$];
  int         fall_q[$];
  logic       rs_q[$];
  logic [7:0] data_q[$];
  logic [8:0] snap;
  int         unstable = 0;
  int         nonzero = 0;

  always @(negedge clk) begin
    cyc++;
    if (rd_en) rd_q.push_back(cyc);
    if (LCD_E && !e_prev) begin
      rise_q.push_back(cyc);
      rs_q.push_back(LCD_RS);
      data_q.push_back(LCD_DATA);
      snap = {LCD_RS, LCD_DATA};
    end else if (LCD_E && ({LCD_RS, LCD_DATA} != snap)) begin
      unstable++;
    end
    if (!LCD_E && e_prev) fall_q.push_back(cyc);
    if (rd_en || LCD_RS || LCD_RW || LCD_E || busy || LCD_DATA != 8'h00 || byte_cnt != 8'h00)
      nonzero++;
    e_prev = LCD_E;
  end

  logic [7:0] exp_bytes[$];

  task automatic clear_mon();
    rd_q.delete();
    rise_q.delete();
    fall_q.delete();
    rs_q.delete();
    data_q.delete();
    unstable = 0;
    nonzero  = 0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 rst = 1'b0;
    fifo_q.delete();
    glitch_low = 1'b0;
    repeat (2) @(negedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 clear_mon();
  endtask

  task automatic push_expected();
    foreach (exp_bytes[i]) fifo_q.push_back(exp_bytes[i]);
  endtask

  task automatic wait_idle(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (fifo_q.size() == 0 && !busy) begin
        ok = 1'b1;
        break;
      end
    end
    @(negedge clk);
  endtask

  // Reference rules: byte index since reset decides RS; a command byte in
  // 1..3 gets the long wait; every E-fall to next pop gap is T_H+wait+1.
  task automatic check_stream(input int base, input int budget);
    int n, w, exp_cnt;
    bit ok, rs_exp;
    n = exp_bytes.size();
    wait_idle(budget, ok);
    n_cmp++;
    if (!ok) begin
      n_err++;
      $display("FAIL idle_timeout: busy=%0b fifo_left=%0d, required idle within %0d cycles",
               busy, fifo_q.size(), budget);
    end
    n_cmp++;
    if (rd_q.size() != n) begin
      n_err++;
      $display("FAIL rd_pulse_count: got %0d required %0d", rd_q.size(), n);
    end
    n_cmp++;
    if (rise_q.size() != n || fall_q.size() != n) begin
      n_err++;
      $display("FAIL e_pulse_count: got rises %0d falls %0d required %0d",
               rise_q.size(), fall_q.size(), n);
    end
    if (rd_q.size() == n && rise_q.size() == n && fall_q.size() == n) begin
      for (int i = 0; i < n; i++) begin
        rs_exp = ((base + i) >= P_CMD);
        w = (!rs_exp && exp_bytes[i] inside {8'h01, 8'h02, 8'h03}) ? P_CLR : P_EXEC;
        n_cmp++;
        if (rise_q[i] - rd_q[i] != 2 + P_AS) begin
          n_err++;
          $display("FAIL e_rise_latency[%0d]: got %0d required %0d", i, rise_q[i] - rd_q[i], 2 + P_AS);
        end
        n_cmp++;
        if (fall_q[i] - rise_q[i] != P_PW) begin
          n_err++;
          $display("FAIL e_width[%0d]: got %0d required %0d", i, fall_q[i] - rise_q[i], P_PW);
        end
        n_cmp++;
        if (rs_q[i] !== rs_exp) begin
          n_err++;
          $display("FAIL rs[%0d]: got %0b required %0b", i, rs_q[i], rs_exp);
        end
        n_cmp++;
        if (data_q[i] !== exp_bytes[i]) begin
          n_err++;
          $display("FAIL data[%0d]: got %02h required %02h", i, data_q[i], exp_bytes[i]);
        end
        if (i + 1 < n) begin
          n_cmp++;
          if (rd_q[i+1] - fall_q[i] != P_H + w + 1) begin
            n_err++;
            $display("FAIL gap[%0d]: got %0d required %0d", i, rd_q[i+1] - fall_q[i], P_H + w + 1);
          end
        end
      end
    end
    n_cmp++;
    if (unstable != 0) begin
      n_err++;
      $display("FAIL bus_stable_during_e: got %0d changes required 0", unstable);
    end
    exp_cnt = (base + n > 255) ? 255 : base + n;
    n_cmp++;
    if (byte_cnt !== 8'(exp_cnt)) begin
      n_err++;
      $display("FAIL byte_cnt: got %0d required %0d", byte_cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({rd_en, LCD_RS, LCD_RW, LCD_E, busy} !== 5'b0) begin
      n_err++;
      $display("FAIL reset_ctrl: got rd_en/rs/rw/e/busy=%05b required 00000",
               {rd_en, LCD_RS, LCD_RW, LCD_E, busy});
    end
    n_cmp++;
    if (LCD_DATA !== 8'h00 || byte_cnt !== 8'h00) begin
      n_err++;
      $display("FAIL reset_data: got data=%02h cnt=%0d required 00/0", LCD_DATA, byte_cnt);
    end
    #1 rst = 1'b1;
    @(posedge clk);
    #1 clear_mon();
    repeat (100) @(negedge clk);
    n_cmp++;
    if (rd_q.size() != 0) begin
      n_err++;
      $display("FAIL idle_no_rd: got %0d pulses required 0", rd_q.size());
    end
    n_cmp++;
    if (nonzero != 0) begin
      n_err++;
      $display("FAIL idle_outputs_zero: got %0d nonzero cycles required 0", nonzero);
    end
  endtask

  task automatic test_cmd_sequence();
    int gaps[4] = '{13, 13, 53, 13};
    exp_bytes = '{8'h38, 8'h0C, 8'h01, 8'h06, 8'h4B};
    push_expected();
    check_stream(0, 1000);
    if (rd_q.size() == 5 && fall_q.size() == 5) begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (rd_q[i+1] - fall_q[i] != gaps[i]) begin
          n_err++;
          $display("FAIL clear_vs_exec_gap[%0d]: got %0d required %0d", i, rd_q[i+1] - fall_q[i], gaps[i]);
        end
      end
    end
  endtask

  task automatic test_clear_as_data();
    do_reset();
    exp_bytes = '{8'h38, 8'h0C, 8'h06, 8'h0C, 8'h41, 8'h01, 8'h42};
    push_expected();
    check_stream(0, 1200);
    if (rd_q.size() == 7 && fall_q.size() == 7) begin
      n_cmp++;
      if (rd_q[6] - fall_q[5] != 13) begin
        n_err++;
        $display("FAIL data_01_uses_exec: got %0d required 13", rd_q[6] - fall_q[5]);
      end
    end
  endtask

  task automatic test_reset_midflight();
    bit hit;
    do_reset();
    exp_bytes = '{8'h38, 8'h0C, 8'h06, 8'h0C, 8'h41};
    push_expected();
    hit = 1'b0;
    for (int k = 0; k < 500; k++) begin
      @(negedge clk);
      if (rise_q.size() == 3) begin
        hit = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL third_e_timeout: got %0d rises required 3", rise_q.size());
    end
    #1 rst = 1'b0;
    #1;
    n_cmp++;
    if ({LCD_E, LCD_RS, busy, rd_en} !== 4'b0) begin
      n_err++;
      $display("FAIL async_reset_ctrl: got e/rs/busy/rd=%04b required 0000", {LCD_E, LCD_RS, busy, rd_en});
    end
    n_cmp++;
    if (LCD_DATA !== 8'h00 || byte_cnt !== 8'h00) begin
      n_err++;
      $display("FAIL async_reset_data: got data=%02h cnt=%0d required 00/0", LCD_DATA, byte_cnt);
    end
    repeat (2) @(posedge clk);
    #1 clear_mon();
    @(negedge clk);
    #1 rst = 1'b1;
    exp_bytes = '{8'h0C, 8'h41};
    check_stream(0, 600);
  endtask

  task automatic test_empty_glitch();
    bit hit;
    do_reset();
    exp_bytes = '{8'h38};
    push_expected();
    hit = 1'b0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (fall_q.size() == 1) begin
        hit = 1'b1;
        break;
      end
    end
    n_cmp++;
    if (!hit) begin
      n_err++;
      $display("FAIL glitch_e_timeout: got %0d falls required 1", fall_q.size());
    end
    repeat (4) @(negedge clk);
    @(posedge clk);
    #2 glitch_low = 1'b1;
    @(posedge clk);
    #2 glitch_low = 1'b0;
    repeat (100) @(negedge clk);
    n_cmp++;
    if (rd_q.size() != 1) begin
      n_err++;
      $display("FAIL glitch_no_extra_rd: got %0d pulses required 1", rd_q.size());
    end
    n_cmp++;
    if (busy !== 1'b0 || byte_cnt !== 8'd1) begin
      n_err++;
      $display("FAIL glitch_idle: got busy=%0b cnt=%0d required 0/1", busy, byte_cnt);
    end
  endtask

  task automatic test_random_stream();
    int n;
    for (int r = 0; r < 3; r++) begin
      do_reset();
      exp_bytes.delete();
      n = $urandom_range(12, 6);
      for (int i = 0; i < n; i++) begin
        case ($urandom_range(3, 0))
          0: exp_bytes.push_back(8'h01);
          1: exp_bytes.push_back(8'($urandom_range(3, 2)));
          default: exp_bytes.push_back(8'($urandom));
        endcase
      end
      push_expected();
      check_stream(0, n * 120 + 200);
    end
  endtask

  task automatic test_back_to_back_saturate();
    do_reset();
    exp_bytes.delete();
    for (int i = 0; i < 260; i++) exp_bytes.push_back(8'($urandom_range(255, 4)));
    push_expected();
    check_stream(0, 30000);
  endtask

  initial begin
    test_reset();
    test_cmd_sequence();
    test_clear_as_data();
    test_reset_midflight();
    test_empty_glitch();
    test_random_stream();
    test_back_to_back_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
